e_md_unit: RTL

//   Execute-stage multiply/divide unit owning the HI/LO register pair.

---
 rtl/e_md_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/e_md_unit.sv
// Execute-stage multiply/divide unit that owns the HI/LO register pair.
// A result is computed at start and held until the fixed latency elapses.
//
// state | meaning
// IDLE  | cnt==0; accepts md_start or an MTHI/MTLO write
// RUN   | cnt!=0; counts down and commits the pending result on 1->0
module e_md_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic        md_wr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        md_busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(LAT_MAX + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   pend_hi, pend_hi_d, pend_lo, pend_lo_d, hi_d, lo_d;
    logic          pend_ok, pend_ok_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_s, r_s;
    logic [31:0] rt_safe, q_u, r_u;
    logic        div_zero;

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide via magnitudes; 0x80000000 has magnitude 2^31 as unsigned.
    // A zero divisor is swapped for 1 only to keep the datapath X-free.
    assign div_zero = (rt_val == 32'd0);
    assign a_mag    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign b_mag    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign q_mag    = a_mag / b_safe;
    assign r_mag    = a_mag % b_safe;
    assign q_s      = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s      = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
    assign rt_safe  = div_zero ? 32'd1 : rt_val;
    assign q_u      = rs_val / rt_safe;
    assign r_u      = rs_val % rt_safe;

    assign md_busy = md_start | (cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            pend_hi <= pend_hi_d;
            pend_lo <= pend_lo_d;
            pend_ok <= pend_ok_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt;
        pend_hi_d = pend_hi;
        pend_lo_d = pend_lo;
        pend_ok_d = pend_ok;
        hi_d      = hi;
        lo_d      = lo;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    case (md_op)
                        3'd0: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_ok_d = 1'b1;
                            cnt_d     = CW'(MUL_LAT);
                            state_d   = RUN;
                        end
                        3'd1: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_ok_d = 1'b1;
                            cnt_d     = CW'(MUL_LAT);
                            state_d   = RUN;
                        end
                        3'd2: begin
                            pend_hi_d = r_s;
                            pend_lo_d = q_s;
                            pend_ok_d = !div_zero;
                            cnt_d     = CW'(DIV_LAT);
                            state_d   = RUN;
                        end
                        3'd3: begin
                            pend_hi_d = r_u;
                            pend_lo_d = q_u;
                            pend_ok_d = !div_zero;
                            cnt_d     = CW'(DIV_LAT);
                            state_d   = RUN;
                        end
                        default: ;
                    endcase
                end else if (md_wr) begin
                    if (md_op == 3'd4) hi_d = rs_val;
                    else if (md_op == 3'd5) lo_d = rs_val;
                end
            end
            RUN: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = IDLE;
                    if (pend_ok) begin
                        hi_d = pend_hi;
                        lo_d = pend_lo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
